// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants: data width, register index width and the XZR index.
// Used by legv8_regfile_sb (optional forwarding macro: REGFILE_BYPASS_EN).
package legv8_pkg;

  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;
  localparam int XZR_IDX   = 31;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/legv8_rf_read_port.sv
// One asynchronous read port: selects stored data and busy flag for an index,
// masks the zero register and optionally forwards the in-flight write.
module legv8_rf_read_port
  import legv8_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_IDX_W,
  parameter int ZERO_REG = XZR_IDX
) (
  input  logic [ADDR_W-1:0]      i_idx,
  input  logic [DATA_W-1:0]      i_regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]   i_busy,
  input  logic                   i_byp_en,
  input  logic [ADDR_W-1:0]      i_byp_idx,
  input  logic [DATA_W-1:0]      i_byp_data,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_busy
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic w_is_zero;
  logic w_hit;

  assign w_is_zero = (i_idx == ZERO_IDX);
  // A forwarded write also retires the producer, so the busy flag reads clear.
  assign w_hit     = i_byp_en && (i_byp_idx == i_idx);

  always_comb begin
    o_data = i_regs[i_idx];
    o_busy = i_busy[i_idx];
    if (w_is_zero) begin
      o_data = '0;
      o_busy = 1'b0;
    end else if (w_hit) begin
      o_data = i_byp_data;
      o_busy = 1'b0;
    end
  end

endmodule

// File: rtl/legv8_regfile_sb.sv
// LEGv8 register file with hardwired XZR, synchronous clear and a per-register
// busy scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module legv8_regfile_sb
  import legv8_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_IDX_W,
  parameter int ZERO_REG = XZR_IDX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readRegister1,
  input  logic [ADDR_W-1:0] readRegister2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              markBusy,
  input  logic [ADDR_W-1:0] busyReg,
  output logic              readBusy1,
  output logic              readBusy2
);

  localparam int                NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  logic                w_wr_en;
  logic                w_mark_en;
  logic                w_byp_en;
  logic [ADDR_W-1:0]   w_rd_idx  [2];
  logic [DATA_W-1:0]   w_rd_data [2];
  logic                w_rd_busy [2];

  assign w_wr_en   = RegWrite && (writeReg != ZERO_IDX);
  assign w_mark_en = markBusy && (busyReg != ZERO_IDX);

`ifdef REGFILE_BYPASS_EN
  assign w_byp_en = w_wr_en;
`else
  assign w_byp_en = 1'b0;
`endif

  // Set is applied after clear so a new producer issued on the retiring edge wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_en) begin
        r_regs[writeReg] <= writeData;
        r_busy[writeReg] <= 1'b0;
      end
      if (w_mark_en) begin
        r_busy[busyReg] <= 1'b1;
      end
    end
  end

  assign w_rd_idx[0] = readRegister1;
  assign w_rd_idx[1] = readRegister2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      legv8_rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
      ) u_port (
        .i_idx      (w_rd_idx[gi]),
        .i_regs     (r_regs),
        .i_busy     (r_busy),
        .i_byp_en   (w_byp_en),
        .i_byp_idx  (writeReg),
        .i_byp_data (writeData),
        .o_data     (w_rd_data[gi]),
        .o_busy     (w_rd_busy[gi])
      );
    end
  endgenerate

  assign readData1 = w_rd_data[0];
  assign readData2 = w_rd_data[1];
  assign readBusy1 = w_rd_busy[0];
  assign readBusy2 = w_rd_busy[1];

endmodule

// File: tb/tb_legv8_regfile_sb.sv
// Bench for legv8_regfile_sb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an array-based reference model.
module tb_legv8_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  writeReg = '0;
  logic [63:0] writeData = '0;
  logic [4:0]  readRegister1 = '0;
  logic [4:0]  readRegister2 = '0;
  logic [63:0] readData1;
  logic [63:0] readData2;
  logic        markBusy = 1'b0;
  logic [4:0]  busyReg = '0;
  logic        readBusy1;
  logic        readBusy2;

  always #5 clk = ~clk;

  legv8_regfile_sb dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .writeReg      (writeReg),
    .writeData     (writeData),
    .readRegister1 (readRegister1),
    .readRegister2 (readRegister2),
    .readData1     (readData1),
    .readData2     (readData2),
    .markBusy      (markBusy),
    .busyReg       (busyReg),
    .readBusy1     (readBusy1),
    .readBusy2     (readBusy2)
  );

  // Reference state: architectural register contents and pending-producer flags.
  logic [63:0] m_regs [32];
  bit          m_busy [32];
  bit          m_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
    if (BYP && RegWrite && writeReg == idx) return writeData;
    return m_regs[idx];
  endfunction

  function automatic logic exp_busy(input logic [4:0] idx);
    if (idx == 5'd31) return 1'b0;
    if (BYP && RegWrite && writeReg == idx) return 1'b0;
    return m_busy[idx];
  endfunction

  task automatic model_compare();
    if (m_valid) begin
      chk("model_rd1_data", readData1, exp_data(readRegister1));
      chk("model_rd1_busy", {63'd0, readBusy1}, {63'd0, exp_busy(readRegister1)});
      chk("model_rd2_data", readData2, exp_data(readRegister2));
      chk("model_rd2_busy", {63'd0, readBusy2}, {63'd0, exp_busy(readRegister2)});
    end
  endtask

  // Apply one cycle of inputs at the falling edge and check the settled outputs.
  task automatic drive(input bit rst, input bit rw, input logic [4:0] wr, input logic [63:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input bit mb, input logic [4:0] br);
    @(negedge clk);
    reset = rst; RegWrite = rw; writeReg = wr; writeData = wd;
    readRegister1 = r1; readRegister2 = r2; markBusy = mb; busyReg = br;
    #1;
    $display("t=%0t rst=%0b we=%0b wr=%0d wd=%h r1=%0d r2=%0d mb=%0b br=%0d | d1=%h b1=%0b d2=%h b2=%0b",
             $time, rst, rw, wr, wd, r1, r2, mb, br, readData1, readBusy1, readData2, readBusy2);
    model_compare();
  endtask

  // Advance through the rising edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 64'd0;
        m_busy[i] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      if (RegWrite && writeReg != 5'd31) begin
        m_regs[writeReg] = writeData;
        m_busy[writeReg] = 1'b0;
      end
      if (markBusy && busyReg != 5'd31) m_busy[busyReg] = 1'b1;
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(1'b0, 1'b0, 5'd0, 64'd0, r1, r2, 1'b0, 5'd0);
  endtask

  initial begin
    logic [4:0]  r1, r2, wr, br;
    logic [63:0] wd;
    bit          rst, rw, mb;

    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();

    // Reset clears earlier writes and busy flags.
    drive(1'b0, 1'b1, 5'd1, 64'd5, 5'd1, 5'd1, 1'b1, 5'd2);
    tick();
    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2, 1'b0, 5'd0);
    tick();
    idle(5'd1, 5'd2);
    chk("t1_x1_data", readData1, 64'd0);
    chk("t1_x2_busy", {63'd0, readBusy2}, 64'd0);

    // Write latency, with or without forwarding.
    drive(1'b0, 1'b1, 5'd12, 64'd64, 5'd12, 5'd0, 1'b0, 5'd0);
    chk("t2_same_cycle", readData1, BYP ? 64'd64 : 64'd0);
    tick();
    idle(5'd12, 5'd12);
    chk("t2_after_edge", readData1, 64'd64);
    chk("t2_port2_same", readData2, 64'd64);

    // Zero register ignores writes and busy marks.
    drive(1'b0, 1'b1, 5'd31, 64'hFFFF, 5'd0, 5'd31, 1'b1, 5'd31);
    chk("t3_xzr_data_now", readData2, 64'd0);
    chk("t3_xzr_busy_now", {63'd0, readBusy2}, 64'd0);
    tick();
    idle(5'd0, 5'd31);
    chk("t3_xzr_data", readData2, 64'd0);
    chk("t3_xzr_busy", {63'd0, readBusy2}, 64'd0);

    // Mark busy, then retire with a write.
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd13, 5'd0, 1'b1, 5'd13);
    tick();
    idle(5'd13, 5'd0);
    chk("t4_busy_set", {63'd0, readBusy1}, 64'd1);
    tick();
    drive(1'b0, 1'b1, 5'd13, 64'd69, 5'd13, 5'd0, 1'b0, 5'd0);
    chk("t4_busy_wr_cycle", {63'd0, readBusy1}, BYP ? 64'd0 : 64'd1);
    tick();
    idle(5'd13, 5'd13);
    chk("t4_busy_clr", {63'd0, readBusy1}, 64'd0);
    chk("t4_data", readData1, 64'd69);

    // Same-edge mark and write: data lands, busy stays set.
    drive(1'b0, 1'b1, 5'd4, 64'd25, 5'd4, 5'd0, 1'b1, 5'd4);
    chk("t5_busy_same_cycle", {63'd0, readBusy1}, 64'd0);
    tick();
    idle(5'd4, 5'd4);
    chk("t5_data", readData1, 64'd25);
    chk("t5_busy", {63'd0, readBusy2}, 64'd1);

    // Reset overrides a concurrent write.
    drive(1'b1, 1'b1, 5'd4, 64'd7, 5'd4, 5'd4, 1'b0, 5'd0);
    tick();
    idle(5'd4, 5'd4);
    chk("t6_data", readData1, 64'd0);
    chk("t6_busy", {63'd0, readBusy1}, 64'd0);
    tick();

    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      rw  = 1'($urandom_range(0, 1));
      mb  = ($urandom_range(0, 2) == 0);
      wr  = 5'($urandom_range(0, 31));
      wd  = {$urandom, $urandom};
      r1  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      br  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      drive(rst, rw, wr, wd, r1, r2, mb, br);
      tick();
    end

    idle(5'd0, 5'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
